game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: frame-paced game flow controller (welcome, play, crash hold, win).
// Every decision advances on a synchronized rising edge of the VGA vertical sync.
module game_sequencer #(
  parameter int         RST_FRAMES  = 2,
  parameter int         HOLD_FRAMES = 120,
  parameter int         LIVES_INIT  = 3,
  parameter logic [7:0] START_KEY   = 8'h28
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [15:0] keycode,
  input  logic        crash,
  input  logic        win,
  output logic [1:0]  state,
  output logic        welcomepage,
  output logic        gamereset,
  output logic [1:0]  lives,
  output logic [15:0] play_frames
);

  typedef enum logic [1:0] {
    S_WELCOME = 2'd0,
    S_PLAY    = 2'd1,
    S_CRASH   = 2'd2,
    S_WIN     = 2'd3
  } state_t;

  localparam logic [15:0] RST_LOAD   = 16'(RST_FRAMES);
  localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_FRAMES);
  localparam logic [1:0]  LIVES_LOAD = 2'(LIVES_INIT);

  state_t      r_state;
  logic        r_fsync1;
  logic        r_fsync2;
  logic        r_fprev;
  logic        r_startPrev;
  logic [15:0] r_rstCnt;
  logic [15:0] r_holdCnt;
  logic [15:0] r_playFrames;
  logic [1:0]  r_lives;
  logic        r_welcome;
  logic        r_gameReset;

  logic        w_frameTick;
  logic        w_startNow;
  logic        w_startHit;
  logic [15:0] w_playInc;

  // frame_clk comes from the VGA domain; r_fprev turns the synchronized level into a one-Clk pulse
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fsync1 <= 1'b0;
      r_fsync2 <= 1'b0;
      r_fprev  <= 1'b0;
    end else begin
      r_fsync1 <= frame_clk;
      r_fsync2 <= r_fsync1;
      r_fprev  <= r_fsync2;
    end
  end

  assign w_frameTick = r_fsync2 & ~r_fprev;
  assign w_startNow  = (keycode[7:0] == START_KEY) || (keycode[15:8] == START_KEY);
  assign w_startHit  = w_startNow & ~r_startPrev;
  assign w_playInc   = (r_playFrames == 16'hFFFF) ? r_playFrames : r_playFrames + 16'd1;

  // play_frames only counts PLAY ticks that leave gamereset low, so the reset frames are not scored
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_WELCOME;
      r_startPrev  <= 1'b0;
      r_rstCnt     <= 16'd0;
      r_holdCnt    <= 16'd0;
      r_playFrames <= 16'd0;
      r_lives      <= LIVES_LOAD;
      r_welcome    <= 1'b1;
      r_gameReset  <= 1'b1;
    end else if (w_frameTick) begin
      r_startPrev <= w_startNow;
      unique case (r_state)
        S_WELCOME: begin
          if (w_startHit) begin
            r_state      <= S_PLAY;
            r_rstCnt     <= RST_LOAD;
            r_playFrames <= 16'd0;
            r_welcome    <= 1'b0;
            r_gameReset  <= (RST_LOAD != 16'd0);
          end
        end
        S_PLAY: begin
          if (r_rstCnt != 16'd0) begin
            r_rstCnt <= r_rstCnt - 16'd1;
            if (r_rstCnt == 16'd1) begin
              r_gameReset  <= 1'b0;
              r_playFrames <= w_playInc;
            end
          end else if (crash) begin
            r_state   <= S_CRASH;
            r_lives   <= (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
            r_holdCnt <= HOLD_LOAD;
          end else if (win) begin
            r_state <= S_WIN;
          end else begin
            r_playFrames <= w_playInc;
          end
        end
        S_CRASH: begin
          if (r_holdCnt <= 16'd1) begin
            r_holdCnt <= 16'd0;
            if (r_lives != 2'd0) begin
              r_state      <= S_PLAY;
              r_rstCnt     <= RST_LOAD;
              r_playFrames <= 16'd0;
              r_gameReset  <= (RST_LOAD != 16'd0);
            end else begin
              r_state     <= S_WELCOME;
              r_lives     <= LIVES_LOAD;
              r_welcome   <= 1'b1;
              r_gameReset <= 1'b1;
            end
          end else begin
            r_holdCnt <= r_holdCnt - 16'd1;
          end
        end
        S_WIN: begin
          if (w_startHit) begin
            r_state     <= S_WELCOME;
            r_lives     <= LIVES_LOAD;
            r_welcome   <= 1'b1;
            r_gameReset <= 1'b1;
          end
        end
      endcase
    end
  end

  assign state       = r_state;
  assign welcomepage = r_welcome;
  assign gamereset   = r_gameReset;
  assign lives       = r_lives;
  assign play_frames = r_playFrames;

endmodule
